// File: rtl/sreg_readout_pkg.sv
// Shared definitions for the SRAM readback path: FSM state encoding,
// default geometry and a counter-width helper.
package sreg_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH   = 32'd8;
    localparam int unsigned DEF_OE_WAIT = 32'd2;
    // Wide enough for OE_WAIT-1 over the whole legal OE_WAIT range 1..15.
    localparam int unsigned WCNT_W      = 32'd4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sreg_readout_down_counter.sv
// Loadable down counter with a zero flag; used for the OE wait time and
// the bit count of the readback shifter.
module down_counter #(
    parameter int unsigned W = 32'd4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != ZERO)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == ZERO);

endmodule

// File: rtl/sreg_readout.sv
// SRAM-to-AVR readback: fetch the addressed byte with a timed OE window,
// then shift it out MSB-first and pulse addr_inc for streaming reads.
module sreg_readout
    import sreg_readout_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned OE_WAIT = DEF_OE_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en_n,
    input  logic [WIDTH-1:0] sram_data,
    output logic             sram_oe_n,
    output logic             so,
    output logic             busy,
    output logic             done,
    output logic             addr_inc,
    output logic [7:0]       debug
);

    localparam int unsigned       BW         = cnt_width(WIDTH);
    localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(OE_WAIT - 32'd1);
    localparam logic [BW-1:0]     BITS_LOAD  = BW'(WIDTH - 32'd1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             oe_n_q;
    logic             oe_n_d;

    logic              accept_s;
    logic              wload_s;
    logic              wdec_s;
    logic              wzero_s;
    logic [WCNT_W-1:0] wcnt_s;
    logic              wcnt_unused_s;
    logic              bload_s;
    logic              bdec_s;
    logic              bzero_s;
    logic [BW-1:0]     bcnt_s;
    logic [2:0]        bcnt_dbg_s;

    assign accept_s      = load && !en_n;
    assign wcnt_unused_s = ^wcnt_s;

    down_counter #(.W(WCNT_W)) u_wcnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wload_s),
        .load_val_i (WAIT_LOAD),
        .dec_i      (wdec_s),
        .count_o    (wcnt_s),
        .zero_o     (wzero_s)
    );

    down_counter #(.W(BW)) u_bcnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bload_s),
        .load_val_i (BITS_LOAD),
        .dec_i      (bdec_s),
        .count_o    (bcnt_s),
        .zero_o     (bzero_s)
    );

    // Next-state, shifter and counter control; WAIT deliberately ignores en_n.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        oe_n_d  = oe_n_q;
        wload_s = 1'b0;
        wdec_s  = 1'b0;
        bload_s = 1'b0;
        bdec_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_WAIT;
                    oe_n_d  = 1'b0;
                    wload_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wzero_s) begin
                    shreg_d = sram_data;
                    oe_n_d  = 1'b1;
                    bload_s = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    wdec_s  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (en_n) begin
                    state_d = ST_SHIFT;
                end else if (!bzero_s) begin
                    shreg_d = shreg_q << 1;
                    bdec_s  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    // FSM, shifter and OE registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            oe_n_q  <= oe_n_d;
        end
    end

    if (BW >= 32'd3) begin : g_dbg_trunc
        assign bcnt_dbg_s = bcnt_s[2:0];
    end else begin : g_dbg_pad
        assign bcnt_dbg_s = {{(3 - BW){1'b0}}, bcnt_s};
    end

    assign so        = shreg_q[WIDTH-1];
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign addr_inc  = (state_q == ST_DONE);
    assign sram_oe_n = oe_n_q;
    assign debug     = {state_q, bcnt_dbg_s, so, busy, sram_oe_n};

endmodule

// File: tb/tb_sreg_readout.sv
// Self-checking bench for sreg_readout: cycle model of the transfer timeline
// plus directed scenarios with hand-computed bit streams and latencies.
module tb_sreg_readout;

    localparam int WIDTH   = 8;
    localparam int OE_WAIT = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b1;
    logic       en_n  = 1'b0;
    logic [7:0] sram_data = 8'h00;
    logic       sram_oe_n, so, busy, done, addr_inc;
    logic [7:0] debug;

    int n_checks = 0;
    int n_fail   = 0;

    sreg_readout #(.WIDTH(WIDTH), .OE_WAIT(OE_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .en_n      (en_n),
        .sram_data (sram_data),
        .sram_oe_n (sram_oe_n),
        .so        (so),
        .busy      (busy),
        .done      (done),
        .addr_inc  (addr_inc),
        .debug     (debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 fetching (m_wleft OE-low cycles left), 2 shifting
    // (m_cons bits consumed), 3 done. so is bit (WIDTH-1-m_cons) of the fetched byte.
    logic [1:0] m_mode = 2'd0;
    int         m_wleft = 0;
    int         m_cons  = 0;
    logic [7:0] m_byte  = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 2'd0; m_wleft <= 0; m_cons <= 0; m_byte <= 8'h00;
        end else begin
            case (m_mode)
                2'd0, 2'd3: begin
                    if (load && !en_n) begin m_mode <= 2'd1; m_wleft <= OE_WAIT; end
                    else m_mode <= 2'd0;
                end
                2'd1: begin
                    if (m_wleft == 1) begin m_byte <= sram_data; m_cons <= 0; m_mode <= 2'd2; end
                    else m_wleft <= m_wleft - 1;
                end
                2'd2: begin
                    if (!en_n) begin
                        if (m_cons == WIDTH - 1) m_mode <= 2'd3;
                        else m_cons <= m_cons + 1;
                    end
                end
                default: m_mode <= 2'd0;
            endcase
        end
    end

    int   cyc = 0;
    int   done_t[$];
    bit   bits[$];
    bit   prev_shift = 1'b0;
    bit   prev_so = 1'b0;
    logic edge_en, edge_rst;

    // Compare against the model every cycle and log consumed bits / done pulses.
    always @(posedge clk) begin
        logic       e_oe, e_busy, e_done, e_so;
        logic [2:0] e_bcnt;
        edge_en  = en_n;
        edge_rst = reset;
        #1;
        cyc++;
        e_oe   = (m_mode != 2'd1);
        e_busy = (m_mode == 2'd1) || (m_mode == 2'd2);
        e_done = (m_mode == 2'd3);
        e_so   = m_byte[WIDTH - 1 - m_cons];
        e_bcnt = (m_mode == 2'd2) ? 3'(WIDTH - 1 - m_cons) : 3'd0;
        check("cmp_sram_oe_n", sram_oe_n, e_oe);
        check("cmp_so", so, e_so);
        check("cmp_busy", busy, e_busy);
        check("cmp_done", done, e_done);
        check("cmp_addr_inc", addr_inc, e_done);
        check("cmp_debug", debug, {m_mode, e_bcnt, e_so, e_busy, e_oe});
        if (prev_shift && !edge_en && !edge_rst) bits.push_back(prev_so);
        prev_shift = (debug[7:6] == 2'd2);
        prev_so    = so;
        if (done) done_t.push_back(cyc);
    end

    function automatic logic [7:0] bits_byte(input int start);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++)
            v = {v[6:0], (start + i < bits.size()) ? bits[start + i] : 1'b0};
        return v;
    endfunction

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_t.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", (done_t.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_bits(input int target, input int budget);
        int k;
        k = 0;
        while (bits.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("bits_timeout", (bits.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        done_t.delete();
        bits.delete();
    endtask

    initial begin
        int t0;
        // 1. reset with load high, then idle until a load is sampled
        repeat (3) @(negedge clk);
        check("rst_oe_n", sram_oe_n, 1'b1);
        check("rst_so", so, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr_inc", addr_inc, 1'b0);
        check("rst_debug", debug, 8'h01);
        reset = 1'b0;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_debug", debug, 8'h01);

        // 2. single read of A5
        clear_logs();
        sram_data = 8'hA5;
        t0 = cyc; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check("single_oe_low", sram_oe_n, 1'b0);
        wait_done(1, 30);
        repeat (4) @(negedge clk);
        check("single_latency", done_t[0] - t0, 11);
        check("single_done_count", done_t.size(), 1);
        check("single_bits", bits_byte(0), 8'hA5);
        check("single_nbits", bits.size(), 8);

        // 3. stall three cycles while the 3rd bit is presented
        clear_logs();
        t0 = cyc; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_bits(2, 30);
        en_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_so_hold", so, 1'b1);
            @(negedge clk);
        end
        en_n = 1'b0;
        wait_done(1, 30);
        repeat (2) @(negedge clk);
        check("stall_latency", done_t[0] - t0, 14);
        check("stall_bits", bits_byte(0), 8'hA5);

        // 4. streaming with load held high
        clear_logs();
        sram_data = 8'h3C;
        load = 1'b1;
        wait_done(1, 30);
        sram_data = 8'hC3;
        wait_done(2, 30);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("stream_spacing", done_t[1] - done_t[0], 11);
        check("stream_byte0", bits_byte(0), 8'h3C);
        check("stream_byte1", bits_byte(8), 8'hC3);
        check("stream_idle", debug[7:6], 2'd0);

        // 5. abort mid-shift after 4 bits, then a clean refetch
        clear_logs();
        sram_data = 8'hFF;
        load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_bits(4, 30);
        check("abort_so_before", so, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_oe_n", sram_oe_n, 1'b1);
        check("abort_so", so, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_t.size(), 0);
        clear_logs();
        sram_data = 8'h5A;
        t0 = cyc; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_done(1, 30);
        check("refetch_latency", done_t[0] - t0, 11);
        check("refetch_bits", bits_byte(0), 8'h5A);

        // 6. loads during WAIT/SHIFT ignored, data changes after capture ignored
        repeat (3) @(negedge clk);
        clear_logs();
        sram_data = 8'h81;
        t0 = cyc; load = 1'b1;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk); load = 1'b1; sram_data = 8'h00;
        @(negedge clk); load = 1'b0;
        @(negedge clk); load = 1'b1; sram_data = 8'hFF;
        @(negedge clk); load = 1'b0;
        wait_done(1, 30);
        repeat (15) @(negedge clk);
        check("ignload_latency", done_t[0] - t0, 11);
        check("ignload_done_count", done_t.size(), 1);
        check("ignload_bits", bits_byte(0), 8'h81);
        check("ignload_nbits", bits.size(), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
